// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states
// and access legality helpers.
package lsu_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RDWAIT,
        RESP
    } lsu_state_e;

    function automatic logic is_legal(input logic we, input logic [2:0] funct3);
        if (we)
            return (funct3 == SB) || (funct3 == SH) || (funct3 == SW);
        return (funct3 == LB) || (funct3 == LH) || (funct3 == LW) ||
               (funct3 == LBU) || (funct3 == LHU);
    endfunction

    // Store encodings coincide with LH/LW, so one check covers both directions.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
        case (funct3)
            LH, LHU: return off[0];
            LW:      return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: store byte enables / replicated write data,
// and load byte/halfword extraction with sign or zero extension.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext
);

    logic [31:0] shifted;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign shifted  = rdata >> {off, 3'b000};
    assign byte_sel = shifted[7:0];
    assign half_sel = off[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        be         = 4'b1111;
        wdata_lane = '0;
        if (we) begin
            case (funct3)
                SB: begin
                    be         = 4'b0001 << off;
                    wdata_lane = {4{wdata[7:0]}};
                end
                SH: begin
                    be         = off[1] ? 4'b1100 : 4'b0011;
                    wdata_lane = {2{wdata[15:0]}};
                end
                default: begin
                    be         = 4'b1111;
                    wdata_lane = wdata;
                end
            endcase
        end
    end

    always_comb begin
        case (funct3)
            LB:      rdata_ext = {{24{byte_sel[7]}}, byte_sel};
            LH:      rdata_ext = {{16{half_sel[15]}}, half_sel};
            LW:      rdata_ext = rdata;
            LBU:     rdata_ext = {24'b0, byte_sel};
            LHU:     rdata_ext = {16'b0, half_sel};
            default: rdata_ext = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: one outstanding access, registered memory-side outputs.
// Define LSU_MISALIGN_TRAP_EN to report misaligned halfword/word accesses as errors.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  m_req,
    output logic                  m_we,
    output logic [3:0]            m_be,
    output logic [DM_ADDRESS-1:0] m_addr,
    output logic [DATA_W-1:0]     m_wdata,
    input  logic                  m_gnt,
    input  logic                  m_rvalid,
    input  logic [DATA_W-1:0]     m_rdata
);

    lsu_state_e state_q, state_d;

    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  off_q, off_d;

    logic                  m_req_d, m_we_d, rsp_valid_d, rsp_err_d;
    logic [3:0]            m_be_d;
    logic [DM_ADDRESS-1:0] m_addr_d;
    logic [DATA_W-1:0]     m_wdata_d, rsp_rdata_d;

    logic        al_we;
    logic [2:0]  al_funct3;
    logic [1:0]  al_off;
    logic [3:0]  al_be;
    logic [31:0] al_wdata, al_rdata;
    logic        bad_access;
    logic        unused_addr;

    assign req_ready   = (state_q == IDLE);
    assign unused_addr = ^req_addr[31:DM_ADDRESS];

    // One aligner serves both directions: live request fields while idle, captured ones afterwards.
    assign al_we     = (state_q == IDLE) ? req_we             : we_q;
    assign al_funct3 = (state_q == IDLE) ? req_funct3         : funct3_q;
    assign al_off    = (state_q == IDLE) ? req_addr[1:0]      : off_q;

    lsu_lane_align u_align (
        .we         (al_we),
        .funct3     (al_funct3),
        .off        (al_off),
        .wdata      (req_wdata),
        .rdata      (m_rdata),
        .be         (al_be),
        .wdata_lane (al_wdata),
        .rdata_ext  (al_rdata)
    );

`ifdef LSU_MISALIGN_TRAP_EN
    assign bad_access = !is_legal(req_we, req_funct3) || is_misaligned(req_funct3, req_addr[1:0]);
`else
    assign bad_access = !is_legal(req_we, req_funct3);
`endif

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        m_req_d     = m_req;
        m_we_d      = m_we;
        m_be_d      = m_be;
        m_addr_d    = m_addr;
        m_wdata_d   = m_wdata;
        rsp_valid_d = rsp_valid;
        rsp_err_d   = rsp_err;
        rsp_rdata_d = rsp_rdata;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    off_d    = req_addr[1:0];
                    if (bad_access) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        state_d   = REQ;
                        m_req_d   = 1'b1;
                        m_we_d    = req_we;
                        m_be_d    = al_be;
                        m_addr_d  = {req_addr[DM_ADDRESS-1:2], 2'b00};
                        m_wdata_d = al_wdata;
                    end
                end
            end
            REQ: begin
                if (m_gnt) begin
                    m_req_d = 1'b0;
                    m_we_d  = 1'b0;
                    if (we_q) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b0;
                        rsp_rdata_d = '0;
                    end else begin
                        state_d = RDWAIT;
                    end
                end
            end
            RDWAIT: begin
                if (m_rvalid) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = al_rdata;
                end
            end
            RESP: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            funct3_q  <= '0;
            off_q     <= '0;
            m_req     <= 1'b0;
            m_we      <= 1'b0;
            m_be      <= '0;
            m_addr    <= '0;
            m_wdata   <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            funct3_q  <= funct3_d;
            off_q     <= off_d;
            m_req     <= m_req_d;
            m_we      <= m_we_d;
            m_be      <= m_be_d;
            m_addr    <= m_addr_d;
            m_wdata   <= m_wdata_d;
            rsp_valid <= rsp_valid_d;
            rsp_err   <= rsp_err_d;
            rsp_rdata <= rsp_rdata_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table of single accesses with
// immediate grant/read data, plus hand sequences for stalls, stray rvalid and reset.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        m_req, m_we, m_gnt, m_rvalid;
    logic [3:0]  m_be;
    logic [8:0]  m_addr;
    logic [31:0] m_wdata, m_rdata;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    load_store_unit #(.DM_ADDRESS(9), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
    );

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        logic [8:0]  maddr;
        logic [3:0]  be;
        logic [31:0] mwdata;
        logic [31:0] rdata_exp;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vec [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " req_ready"}, 32'(req_ready), 32'd1);
        check({tag, " rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, " rsp_err"},   32'(rsp_err),   32'd0);
        check({tag, " rsp_rdata"}, rsp_rdata,      32'd0);
        check({tag, " m_req"},     32'(m_req),     32'd0);
        check({tag, " m_we"},      32'(m_we),      32'd0);
        check({tag, " m_be"},      32'(m_be),      32'd0);
        check({tag, " m_addr"},    32'(m_addr),    32'd0);
        check({tag, " m_wdata"},   m_wdata,        32'd0);
    endtask

    // Called #1 after a rising edge; grant one cycle after acceptance, read data one after that.
    task automatic run_vec(input int i, input vec_t v);
        string t;
        t = $sformatf("v%0d", i);
        check({t, " req_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3;
        req_addr = v.addr; req_wdata = v.wdata;
        tick();
        req_valid = 1'b0;
        if (v.err) begin
            check({t, " err rsp_valid"}, 32'(rsp_valid), 32'd1);
            check({t, " err rsp_err"},   32'(rsp_err),   32'd1);
            check({t, " err rsp_rdata"}, rsp_rdata,      32'd0);
            check({t, " err m_req"},     32'(m_req),     32'd0);
        end else begin
            check({t, " m_req"},  32'(m_req),  32'd1);
            check({t, " m_we"},   32'(m_we),   32'(v.we));
            check({t, " m_addr"}, 32'(m_addr), 32'(v.maddr));
            check({t, " m_be"},   32'(m_be),   32'(v.be));
            if (v.we) check({t, " m_wdata"}, m_wdata, v.mwdata);
            check({t, " rsp_valid early"}, 32'(rsp_valid), 32'd0);
            m_gnt = 1'b1;
            tick();
            m_gnt = 1'b0;
            if (!v.we) begin
                check({t, " rdwait rsp_valid"}, 32'(rsp_valid), 32'd0);
                m_rvalid = 1'b1; m_rdata = v.rdata;
                tick();
                m_rvalid = 1'b0; m_rdata = '0;
            end
            check({t, " rsp_valid"}, 32'(rsp_valid), 32'd1);
            check({t, " rsp_err"},   32'(rsp_err),   32'd0);
            check({t, " rsp_rdata"}, rsp_rdata,      v.rdata_exp);
        end
        tick();
        check({t, " rsp_valid drop"}, 32'(rsp_valid), 32'd0);
        check({t, " ready again"},    32'(req_ready),  32'd1);
    endtask

    initial begin
        //          we  f3   addr          wdata         rdata         err  maddr   be       mwdata        rdata_exp
        vec[0]  = '{1, SB,  32'h0000_0013, 32'h0000_00AB, 32'h0,        0, 9'h010, 4'b1000, 32'hABAB_ABAB, 32'h0};
        vec[1]  = '{0, LB,  32'h0000_0011, 32'h0,        32'h1234_80FF, 0, 9'h010, 4'b1111, 32'h0,        32'hFFFF_FF80};
        vec[2]  = '{0, LBU, 32'h0000_0011, 32'h0,        32'h1234_80FF, 0, 9'h010, 4'b1111, 32'h0,        32'h0000_0080};
        vec[3]  = '{0, LHU, 32'h0000_0012, 32'h0,        32'h1234_80FF, 0, 9'h010, 4'b1111, 32'h0,        32'h0000_1234};
        vec[4]  = '{0, LH,  32'h0000_0012, 32'h0,        32'h8765_4321, 0, 9'h010, 4'b1111, 32'h0,        32'hFFFF_8765};
        vec[5]  = '{0, LH,  32'h0000_0010, 32'h0,        32'hBEEF_1234, 0, 9'h010, 4'b1111, 32'h0,        32'h0000_1234};
        vec[6]  = '{1, SH,  32'h0000_01FE, 32'h1234_CAFE, 32'h0,        0, 9'h1FC, 4'b1100, 32'hCAFE_CAFE, 32'h0};
        vec[7]  = '{1, SW,  32'h0000_0104, 32'hDEAD_BEEF, 32'h0,        0, 9'h104, 4'b1111, 32'hDEAD_BEEF, 32'h0};
        vec[8]  = '{0, 3'b011, 32'h0000_0020, 32'h0,     32'h0,        1, 9'h0,   4'b0,    32'h0,        32'h0};
        vec[9]  = '{1, 3'b100, 32'h0000_0020, 32'h5555_5555, 32'h0,    1, 9'h0,   4'b0,    32'h0,        32'h0};
        vec[10] = '{0, LW,  32'hFFFF_FE08, 32'h0,        32'hCAFE_F00D, 0, 9'h008, 4'b1111, 32'h0,        32'hCAFE_F00D};
        vec[11] = '{0, LBU, 32'h0000_0003, 32'h0,        32'hF100_0000, 0, 9'h000, 4'b1111, 32'h0,        32'h0000_00F1};
        vec[12] = '{0, LB,  32'h0000_0003, 32'h0,        32'hF100_0000, 0, 9'h000, 4'b1111, 32'h0,        32'hFFFF_FFF1};
`ifdef LSU_MISALIGN_TRAP_EN
        vec[13] = '{0, LW,  32'h0000_0006, 32'h0,        32'h1122_3344, 1, 9'h0,   4'b0,    32'h0,        32'h0};
        vec[14] = '{1, SH,  32'h0000_0013, 32'h0000_BEEF, 32'h0,        1, 9'h0,   4'b0,    32'h0,        32'h0};
`else
        vec[13] = '{0, LW,  32'h0000_0006, 32'h0,        32'h1122_3344, 0, 9'h004, 4'b1111, 32'h0,        32'h1122_3344};
        vec[14] = '{1, SH,  32'h0000_0013, 32'h0000_BEEF, 32'h0,        0, 9'h010, 4'b1100, 32'hBEEF_BEEF, 32'h0};
`endif

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0; m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
        tick();
        tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < NVEC; i++) run_vec(i, vec[i]);

        // Grant withheld for five cycles; rvalid coinciding with the grant must be ignored.
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = LW; req_addr = 32'h0000_000C;
        tick();
        req_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("stall%0d m_req", c),     32'(m_req),     32'd1);
            check($sformatf("stall%0d m_addr", c),    32'(m_addr),    32'h00C);
            check($sformatf("stall%0d m_be", c),      32'(m_be),      32'hF);
            check($sformatf("stall%0d m_we", c),      32'(m_we),      32'd0);
            check($sformatf("stall%0d req_ready", c), 32'(req_ready), 32'd0);
            tick();
        end
        check("stall grant m_req", 32'(m_req), 32'd1);
        m_gnt = 1'b1; m_rvalid = 1'b1; m_rdata = 32'hDEAD_0000;
        tick();
        m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
        check("stall post-gnt m_req", 32'(m_req), 32'd0);
        check("stall post-gnt rsp_valid", 32'(rsp_valid), 32'd0);
        tick();
        check("stall same-cycle rvalid ignored", 32'(rsp_valid), 32'd0);
        check("stall rdwait req_ready", 32'(req_ready), 32'd0);
        m_rvalid = 1'b1; m_rdata = 32'h55AA_00FF;
        tick();
        m_rvalid = 1'b0; m_rdata = '0;
        check("stall rsp_valid", 32'(rsp_valid), 32'd1);
        check("stall rsp_rdata", rsp_rdata, 32'h55AA_00FF);
        tick();
        check("stall rsp_valid pulse", 32'(rsp_valid), 32'd0);
        check("stall ready again", 32'(req_ready), 32'd1);

        // Stray rvalid while idle.
        m_rvalid = 1'b1; m_rdata = 32'h1234_5678;
        tick();
        tick();
        m_rvalid = 1'b0; m_rdata = '0;
        check("stray rsp_valid", 32'(rsp_valid), 32'd0);
        check("stray req_ready", 32'(req_ready), 32'd1);
        tick();
        check("stray rsp_valid late", 32'(rsp_valid), 32'd0);

        // Reset while waiting for read data, then a clean store.
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = LW; req_addr = 32'h0000_0044;
        tick();
        req_valid = 1'b0;
        m_gnt = 1'b1;
        tick();
        m_gnt = 1'b0;
        check("rst pre req_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        #2;
        rst_n = 1'b1;
        tick();
        m_rvalid = 1'b1; m_rdata = 32'hAAAA_5555;
        tick();
        m_rvalid = 1'b0; m_rdata = '0;
        check("postrst rsp_valid", 32'(rsp_valid), 32'd0);
        run_vec(99, '{1, SW, 32'h0000_0080, 32'h0BAD_F00D, 32'h0, 0, 9'h080, 4'b1111, 32'h0BAD_F00D, 32'h0});

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator-side load/store unit in the MEM stage of the RISC-V pipeline. It accepts one load or store per transaction from the pipeline and generates word-aligned requests with byte enables toward the data memory. It holds a request until the memory grants it, waits for read data, and returns sign- or zero-extended load results. The pipeline stalls on `req_ready` while a transaction is outstanding.

## Interface
- `DM_ADDRESS`, 9: memory address width in bytes; `m_addr` width.
- `DATA_W`, 32: data width; only 32 is supported.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `req_valid`  in  1  pipeline presents an access
- `req_ready`  out  1  unit can accept an access; high only in IDLE
- `req_we`  in  1  1 = store (MemWrite), 0 = load (MemRead)
- `req_funct3`  in  3  instruction bits 14:12
- `req_addr`  in  32  ALU byte address
- `req_wdata`  in  32  store data, rs2 value
- `rsp_valid`  out  1  one-cycle pulse: load data or error ready
- `rsp_rdata`  out  32  extended load data; 0 for stores and errors
- `rsp_err`  out  1  valid with `rsp_valid`: illegal or misaligned access
- `m_req`  out  1  memory request
- `m_we`  out  1  memory write
- `m_be`  out  4  byte enables
- `m_addr`  out  DM_ADDRESS  word-aligned address, low 2 bits forced to 0
- `m_wdata`  out  32  lane-aligned write data
- `m_gnt`  in  1  memory accepts the request this cycle
- `m_rvalid`  in  1  read data valid
- `m_rdata`  in  32  read word

## Operation
- **FSM states:** IDLE, REQ, RDWAIT, RESP.
  - IDLE, on `req_valid`: the access is captured.
    - Legal access: go to REQ.
    - Illegal access: go to RESP with `rsp_err`=1 and no memory request.
  - REQ: `m_req`=1 and all `m_*` outputs are held stable until `m_gnt`.
    - On grant, a store goes to RESP and a load goes to RDWAIT.
  - RDWAIT: on `m_rvalid`, `m_rdata` is captured, extracted and extended; go to RESP.
  - RESP: `rsp_valid`=1 for one cycle, then IDLE.
  - Stores also pulse `rsp_valid`, with `rsp_err`=0 and `rsp_rdata`=0.
- **Legal funct3 values:** loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW. Any other value is illegal and always errors.
- **Byte enables and write data** (`off` = `req_addr[1:0]`):
  - SB: `m_be` = 1<<off; the byte is replicated on all 4 lanes.
  - SH: `m_be` = 0011 if off[1]=0, else 1100; the halfword is replicated on both halves.
  - SW: `m_be` = 1111.
  - Loads: `m_be` = 1111, `m_we`=0.
- **Load extraction:** select the byte at lane off, or the halfword at off[1]. LB and LH sign-extend; LBU and LHU zero-extend.
- `m_addr` = {`req_addr[DM_ADDRESS-1:2]`, 2'b00}. Upper address bits are ignored.

## Timing
- Reset values: `req_ready`=1, `rsp_valid`=0, `rsp_err`=0, `rsp_rdata`=0, `m_req`=0, `m_we`=0, `m_be`=0, `m_addr`=0, `m_wdata`=0, state IDLE.
- All outputs are registered, except `req_ready`, which is decoded from state.
- **Latency** (access accepted at cycle T):
  - `m_req` rises at T+1.
  - With `m_gnt` at T+1, a store responds at T+2.
  - A load with `m_rvalid` at T+2 responds at T+3. The next access can be accepted at T+4.
- **Handshake edge cases:**
  - `m_rvalid` is honoured only in RDWAIT. If it arrives in the same cycle as `m_gnt`, or while IDLE, it is ignored.
  - There is no back-to-back pipelining: at most one transaction is outstanding.
- **Reset mid-transaction:** `rst_n` low returns the unit to IDLE immediately. The in-flight access is discarded and no `rsp_valid` is issued.
- Unbounded `m_gnt` or `m_rvalid` delay stalls indefinitely. There is no timeout.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - LH, LHU and SH with off[0]=1, and LW and SW with off≠0, are errors.
  - No memory request is issued; `rsp_valid` and `rsp_err` assert at T+1.
- `LSU_MISALIGN_TRAP_EN` undefined:
  - Offending low address bits are truncated: halfword uses off[1]; word ignores off.
  - The access proceeds normally with `rsp_err`=0.

## Structure
- Package `lsu_pkg`:
  - funct3 encoding constants: LB, LH, LW, LBU, LHU, SB, SH, SW.
  - FSM state enum.
- Sub-module `lsu_lane_align`, purely combinational, computes:
  - store: `m_be` and `m_wdata` from funct3, off and wdata.
  - load: extracted and extended rdata from funct3, off and `m_rdata`.
- The top level holds the FSM and the captured request registers.

## Test plan
- SB with addr=0x0000_0013, wdata=0x0000_00AB, gnt at T+1 → `m_addr`=0x010, `m_be`=1000, `m_wdata`=0xABABABAB, `rsp_valid` at T+2.
- LB at addr=0x11, `m_rdata`=0x1234_80FF → `rsp_rdata`=0xFFFF_FF80. LBU at the same address → 0x0000_0080. LHU at addr=0x12 → 0x0000_1234.
- LW with `m_gnt` withheld for 5 cycles → `m_req` held and all `m_*` stable, `req_ready`=0 throughout; `rsp_valid` exactly one cycle after `m_rvalid`.
- LW at addr=0x06:
  - With `LSU_MISALIGN_TRAP_EN` defined → no `m_req`, `rsp_err`=1 at T+1.
  - With it undefined → `m_addr`=0x004, `rsp_err`=0.
- funct3=011 load → `rsp_err`=1 and no memory request. Stray `m_rvalid` while IDLE → no `rsp_valid`.
- `rst_n` pulsed low while in RDWAIT → all outputs return to reset values, then a subsequent SW completes normally.
